// File: rtl/bids_n_if.sv
// bids_n_if: signal bundle between the auction controller and its bidders.
//   master : auctioneer/bidder side (drives bids, retracts and controller ops)
//   slave  : bids_n controller side (drives acks, errors, balances, results)
// Bidder channel: bid_amt, bid, retract -> ack, bid_err, balance, win
// Controller    : C_data, C_op, C_sel, C_start -> ready, err, roundOver, maxBid
interface bids_n_if #(
  parameter int N_BIDDERS = 3,
  parameter int AMT_W     = 16,
  parameter int BAL_W     = 32
);
  localparam int SEL_W = (N_BIDDERS > 1) ? $clog2(N_BIDDERS) : 1;

  logic [N_BIDDERS*AMT_W-1:0] bid_amt;
  logic [N_BIDDERS-1:0]       bid;
  logic [N_BIDDERS-1:0]       retract;
  logic [31:0]                C_data;
  logic [3:0]                 C_op;
  logic [SEL_W-1:0]           C_sel;
  logic                       C_start;

  logic [N_BIDDERS-1:0]       ack;
  logic [2*N_BIDDERS-1:0]     bid_err;
  logic [N_BIDDERS*BAL_W-1:0] balance;
  logic [N_BIDDERS-1:0]       win;
  logic                       ready;
  logic [1:0]                 err;
  logic                       roundOver;
  logic [AMT_W-1:0]           maxBid;

  modport master (
    output bid_amt, bid, retract, C_data, C_op, C_sel, C_start,
    input  ack, bid_err, balance, win, ready, err, roundOver, maxBid
  );

  modport slave (
    input  bid_amt, bid, retract, C_data, C_op, C_sel, C_start,
    output ack, bid_err, balance, win, ready, err, roundOver, maxBid
  );
endinterface

// File: rtl/bids_n.sv
// bids_n: N-bidder auction controller with strict-raise bidding, retraction,
// per-bid charging and winner settlement against bidder balances.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - bids_n_if.slave (bidder channels + controller op port)
// Optional feature macro: BIDS_ROUND_TIMER_EN builds the round countdown
// (SetTimer op + forced round end). Without it SetTimer is an invalid op.
//
// state    | meaning
// ---------+----------------------------------------------------------
// LOCKED   | idle, config locked; C_start begins a round
// UNLOCKED | idle, config ops (LoadBal/SetMask/SetTimer/BidCharge) allowed
// ROUND    | bids and retracts accepted each cycle
// RESULT   | one-cycle settlement of the winner, then back to LOCKED
module bids_n #(
  parameter int          N_BIDDERS  = 3,
  parameter int          AMT_W      = 16,
  parameter int          BAL_W      = 32,
  parameter logic [31:0] UNLOCK_KEY = 32'h0F0F0F0F,
  parameter logic [31:0] TIMER_RST  = 32'h0000000F
) (
  input  logic     clk,
  input  logic     reset,
  bids_n_if.slave  bus
);
  localparam int SEL_W = (N_BIDDERS > 1) ? $clog2(N_BIDDERS) : 1;

  localparam logic [3:0] OP_NOOP     = 4'd0;
  localparam logic [3:0] OP_UNLOCK   = 4'd1;
  localparam logic [3:0] OP_LOCK     = 4'd2;
  localparam logic [3:0] OP_LOADBAL  = 4'd3;
  localparam logic [3:0] OP_SETMASK  = 4'd4;
  localparam logic [3:0] OP_SETTIMER = 4'd5;
  localparam logic [3:0] OP_CHARGE   = 4'd6;

`ifdef BIDS_ROUND_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_ROUND    = 2'd2,
    ST_RESULT   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [AMT_W-1:0]       cur_q [N_BIDDERS];
  logic [AMT_W-1:0]       cur_d [N_BIDDERS];
  logic [BAL_W-1:0]       bal_q [N_BIDDERS];
  logic [BAL_W-1:0]       bal_d [N_BIDDERS];
  logic [N_BIDDERS-1:0]   mask_q, mask_d;
  logic [BAL_W-1:0]       cost_q, cost_d;
  logic [AMT_W-1:0]       maxbid_q, maxbid_d;
  logic [N_BIDDERS-1:0]   ack_q, ack_d;
  logic [2*N_BIDDERS-1:0] berr_q, berr_d;
  logic [N_BIDDERS-1:0]   win_q, win_d;
  logic                   ready_q, ready_d;
  logic [1:0]             err_q, err_d;
  logic                   rover_q, rover_d;

`ifdef BIDS_ROUND_TIMER_EN
  logic [31:0]            tload_q, tload_d;
  logic [31:0]            cnt_q, cnt_d;
`else
  logic [31:0]            unused_timer_rst;
  assign unused_timer_rst = TIMER_RST;
`endif

  logic [AMT_W-1:0]       amt_w  [N_BIDDERS];
  logic [BAL_W:0]         need_w [N_BIDDERS];
  logic                   op_invalid;
  logic [AMT_W-1:0]       top_amt;
  logic [SEL_W-1:0]       top_idx;
  logic [BAL_W-1:0]       debit;

  for (genvar g = 0; g < N_BIDDERS; g++) begin : g_chan
    assign amt_w[g]  = bus.bid_amt[g*AMT_W +: AMT_W];
    // amount + charge at BAL_W+1 bits so a large charge cannot wrap past the balance
    assign need_w[g] = {1'b0, {(BAL_W-AMT_W){1'b0}}, amt_w[g]} + {1'b0, cost_q};
    assign bus.balance[g*BAL_W +: BAL_W] = bal_q[g];
  end

  assign bus.ack       = ack_q;
  assign bus.bid_err   = berr_q;
  assign bus.win       = win_q;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.roundOver = rover_q;
  assign bus.maxBid    = maxbid_q;

  assign op_invalid = (bus.C_op > OP_CHARGE) || ((bus.C_op == OP_SETTIMER) && !TIMER_EN);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    bal_d    = bal_q;
    mask_d   = mask_q;
    cost_d   = cost_q;
    maxbid_d = maxbid_q;
    ack_d    = '0;
    berr_d   = '0;
    win_d    = win_q;
    err_d    = 2'b00;
    rover_d  = rover_q;
    top_amt  = '0;
    top_idx  = '0;
    debit    = '0;
`ifdef BIDS_ROUND_TIMER_EN
    tload_d  = tload_q;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_LOCKED, ST_UNLOCKED: begin
        if (op_invalid) begin
          err_d = 2'b11;
        end else begin
          case (bus.C_op)
            OP_NOOP: ;
            OP_UNLOCK: begin
              if (state_q != ST_LOCKED)          err_d   = 2'b10;
              else if (bus.C_data == UNLOCK_KEY) state_d = ST_UNLOCKED;
              else                               err_d   = 2'b01;
            end
            OP_LOCK: begin
              if (state_q == ST_UNLOCKED) state_d = ST_LOCKED;
              else                        err_d   = 2'b10;
            end
            default: begin
              if (state_q != ST_UNLOCKED) begin
                err_d = 2'b10;
              end else if (bus.C_op == OP_LOADBAL) begin
                if (int'(bus.C_sel) >= N_BIDDERS) err_d = 2'b11;
                else bal_d[bus.C_sel] = BAL_W'(bus.C_data);
              end else if (bus.C_op == OP_SETMASK) begin
                mask_d = bus.C_data[N_BIDDERS-1:0];
              end else if (bus.C_op == OP_CHARGE) begin
                cost_d = BAL_W'(bus.C_data);
              end else begin
`ifdef BIDS_ROUND_TIMER_EN
                tload_d = bus.C_data;
`endif
              end
            end
          endcase
        end

        // A round start takes precedence over any state change from the op.
        if (bus.C_start) begin
          if (state_q == ST_LOCKED) begin
            state_d  = ST_ROUND;
            for (int i = 0; i < N_BIDDERS; i++) cur_d[i] = '0;
            maxbid_d = '0;
            win_d    = '0;
            rover_d  = 1'b0;
`ifdef BIDS_ROUND_TIMER_EN
            cnt_d    = tload_q;
`endif
          end else begin
            err_d = 2'b11;
          end
        end
      end

      ST_ROUND: begin
        if (bus.C_op != OP_NOOP) err_d = 2'b10;
        for (int i = 0; i < N_BIDDERS; i++) begin
          if (bus.retract[i]) begin
            if (cur_q[i] != '0) begin
              cur_d[i] = '0;
              ack_d[i] = 1'b1;
            end else begin
              berr_d[2*i +: 2] = 2'b01;
            end
          end else if (bus.bid[i]) begin
            if (!mask_q[i]) begin
              berr_d[2*i +: 2] = 2'b11;
            end else if (need_w[i] > {1'b0, bal_q[i]}) begin
              berr_d[2*i +: 2] = 2'b10;
              bal_d[i] = (bal_q[i] >= cost_q) ? (bal_q[i] - cost_q) : '0;
            end else if (amt_w[i] <= maxbid_q) begin
              berr_d[2*i +: 2] = 2'b01;
            end else begin
              cur_d[i] = amt_w[i];
              bal_d[i] = bal_q[i] - cost_q;
              ack_d[i] = 1'b1;
            end
          end
        end
        // Recomputed from scratch so a retracted leader drops out immediately.
        for (int i = 0; i < N_BIDDERS; i++) begin
          if (cur_d[i] > top_amt) top_amt = cur_d[i];
        end
        maxbid_d = top_amt;
`ifdef BIDS_ROUND_TIMER_EN
        if (!bus.C_start || (cnt_q <= 32'd1)) state_d = ST_RESULT;
        else                                  cnt_d   = cnt_q - 32'd1;
`else
        if (!bus.C_start) state_d = ST_RESULT;
`endif
      end

      ST_RESULT: begin
        if (bus.C_op != OP_NOOP) err_d = 2'b10;
        // Strict compare keeps the lowest index on ties.
        for (int i = 0; i < N_BIDDERS; i++) begin
          if (cur_q[i] > top_amt) begin
            top_amt = cur_q[i];
            top_idx = SEL_W'(i);
          end
        end
        if (top_amt != '0) begin
          debit          = {{(BAL_W-AMT_W){1'b0}}, top_amt};
          win_d          = '0;
          win_d[top_idx] = 1'b1;
          bal_d[top_idx] = (bal_q[top_idx] >= debit) ? (bal_q[top_idx] - debit) : '0;
        end
        maxbid_d = top_amt;
        rover_d  = 1'b1;
        state_d  = ST_LOCKED;
      end

      default: state_d = ST_LOCKED;
    endcase

    ready_d = (state_d == ST_LOCKED) || (state_d == ST_UNLOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOCKED;
      for (int i = 0; i < N_BIDDERS; i++) begin
        cur_q[i] <= '0;
        bal_q[i] <= '0;
      end
      mask_q   <= '1;
      cost_q   <= BAL_W'(1);
      maxbid_q <= '0;
      ack_q    <= '0;
      berr_q   <= '0;
      win_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 2'b00;
      rover_q  <= 1'b0;
`ifdef BIDS_ROUND_TIMER_EN
      tload_q  <= TIMER_RST;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      bal_q    <= bal_d;
      mask_q   <= mask_d;
      cost_q   <= cost_d;
      maxbid_q <= maxbid_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
      win_q    <= win_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rover_q  <= rover_d;
`ifdef BIDS_ROUND_TIMER_EN
      tload_q  <= tload_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule
